// File: rtl/bcd_run_ctrl_if.sv
// rtl/bcd_run_ctrl_if.sv - command pulses and counter/display outputs of bcd_run_ctrl
interface bcd_run_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic [15:0] bcd;
  logic [1:0]  state;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output start, stop, clear,
    input  bcd, state, wrap, an, seg
  );

  modport slave (
    input  start, stop, clear,
    output bcd, state, wrap, an, seg
  );
endinterface

// File: rtl/bcd_run_ctrl.sv
// rtl/bcd_run_ctrl.sv - run/stop sequencer for a 4-digit BCD counter with multiplexed 7-segment scan
module bcd_run_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input logic           mclk,
  input logic           rst,
  bcd_run_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            wrap_q, wrap_d;
  logic [SW-1:0]   scan_q;
  logic [1:0]      sel_q;
  logic            tick;
  logic            carry;
  logic [3:0]      digit;
  logic [3:0]      shown;
  logic [6:0]      seg_d;

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    digit   = 4'd0;

    // clear outranks stop, stop outranks start; unlisted pulses fall through
    case (state_q)
      S_IDLE:  if (!bus.clear && bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.clear)     state_d = S_IDLE;
        else if (bus.stop) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (bus.clear)      state_d = S_IDLE;
        else if (bus.start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_q)
      S_RUN:   presc_d = tick ? '0 : presc_q + 1'b1;
      S_PAUSE: presc_d = presc_q;
      default: presc_d = '0;
    endcase

    // ripple the carry through the digits; a carry out of digit 3 is the rollover
    if (tick) begin
      for (int k = 0; k < 4; k++) begin
        digit = bcd_q[4*k +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            bcd_d[4*k +: 4] = 4'd0;
          end else begin
            bcd_d[4*k +: 4] = digit + 4'd1;
            carry           = 1'b0;
          end
        end
      end
      wrap_d = carry;
    end

    if (bus.clear) begin
      bcd_d   = '0;
      presc_d = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      bcd_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      scan_q <= '0;
      sel_q  <= 2'd0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      sel_q  <= sel_q + 2'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  assign shown = bcd_q[{sel_q, 2'b00} +: 4];

  always_comb begin
    seg_d = 7'h7f;
    case (shown)
      4'd0: seg_d = 7'h40;
      4'd1: seg_d = 7'h79;
      4'd2: seg_d = 7'h24;
      4'd3: seg_d = 7'h30;
      4'd4: seg_d = 7'h19;
      4'd5: seg_d = 7'h12;
      4'd6: seg_d = 7'h02;
      4'd7: seg_d = 7'h78;
      4'd8: seg_d = 7'h00;
      4'd9: seg_d = 7'h10;
      default: seg_d = 7'h7f;
    endcase
  end

  assign bus.bcd   = bcd_q;
  assign bus.state = state_q;
  assign bus.wrap  = wrap_q;
  assign bus.an    = ~(4'b0001 << sel_q);
  assign bus.seg   = seg_d;
endmodule

// File: tb/tb_bcd_run_ctrl.sv
// tb/tb_bcd_run_ctrl.sv - scoreboard bench for bcd_run_ctrl against an integer-count reference model
module tb_bcd_run_ctrl;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic mclk = 1'b0;
  logic rst  = 1'b0;
  always #5 mclk = ~mclk;

  bcd_run_ctrl_if bus ();

  bcd_run_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          step;
    logic [1:0]  state;
    logic [15:0] bcd;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // reference model: plain decimal count, run-cycle phase, free-running cycle number
  int   m_state = 0;
  int   m_cnt   = 0;
  int   m_phase = 0;
  int   m_cyc   = 0;
  bit   m_wrap  = 1'b0;
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input int stp, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, stp, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit c);
    exp_t e;
    int   sel;
    int   dig [4];
    @(negedge mclk);
    #1;
    rst       = r;
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
    if (!r) begin
      m_state = 0; m_cnt = 0; m_phase = 0; m_cyc = 0; m_wrap = 1'b0;
    end else begin
      m_cyc++;
      m_wrap = 1'b0;
      if (c) begin
        m_cnt = 0; m_phase = 0;
      end else if (m_state == 1) begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_cnt   = (m_cnt + 1) % 10000;
          m_wrap  = (m_cnt == 0);
        end
      end
      if (c)                                  m_state = 0;
      else if (m_state == 1 && p)             m_state = 2;
      else if ((m_state == 0 || m_state == 2) && s) m_state = 1;
    end
    dig[0] = m_cnt % 10;
    dig[1] = (m_cnt / 10) % 10;
    dig[2] = (m_cnt / 100) % 10;
    dig[3] = (m_cnt / 1000) % 10;
    sel     = (m_cyc / SCAN_DIV) % 4;
    e.step  = step_no;
    e.state = 2'(m_state);
    e.bcd   = {4'(dig[3]), 4'(dig[2]), 4'(dig[1]), 4'(dig[0])};
    e.wrap  = m_wrap;
    e.an    = 4'hf ^ (4'h1 << sel);
    e.seg   = segtab[dig[sel]];
    q.push_back(e);
    step_no++;
  endtask

  task automatic run_until(input int target, input bit tick_next);
    int n = 0;
    while (!(m_cnt == target && (!tick_next || m_phase == TICK_DIV - 1)) && n < 100000) begin
      step(1, 0, 0, 0);
      n++;
    end
  endtask

  always @(negedge mclk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", e.step, int'(bus.state), int'(e.state));
      chk("bcd",   e.step, int'(bus.bcd),   int'(e.bcd));
      chk("wrap",  e.step, int'(bus.wrap),  int'(e.wrap));
      chk("an",    e.step, int'(bus.an),    int'(e.an));
      chk("seg",   e.step, int'(bus.seg),   int'(e.seg));
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;

    repeat (3) step(0, 1'($urandom), 1'($urandom), 1'($urandom));
    repeat (10) step(1, 0, 0, 0);

    // first counts, single- and two-digit carry
    step(1, 1, 0, 0);
    run_until(11, 1'b0);

    // pause keeps the partial period: start e0, stop e2, start e7
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);

    // all three pulses in RUN, then stop landing on the tick edge
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);

    repeat (1500)
      step(($urandom % 200) != 0, ($urandom % 6) == 0,
           ($urandom % 10) == 0, ($urandom % 25) == 0);

    // long run: hold 4321 for a full scan, wrap at 9999, then clear on the 9999 tick
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    run_until(4321, 1'b0);
    step(1, 0, 1, 0);
    repeat (10) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    run_until(999, 1'b1);
    repeat (2) step(1, 0, 0, 0);
    run_until(9999, 1'b1);
    repeat (3) step(1, 0, 0, 0);
    run_until(1, 1'b0);
    run_until(9999, 1'b1);
    step(1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);

    repeat (2) @(negedge mclk);
    #1;
    chk("drain", step_no, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_run_ctrl.md
# bcd_run_ctrl

Run/stop controller for a 4-digit cascaded BCD counter, including its 7-segment multiplexed display. The block divides `mclk` into a count tick and uses a small state machine, driven by single-cycle start/stop/clear pulses, to sequence the counter. It drives a 4-digit common-anode display by time-multiplexing the digits. It sits between the debounced button logic and the board's segment/anode pins.

## Interface
- `TICK_DIV`, default 50000000: `mclk` cycles per count tick; must be >= 2.
- `SCAN_DIV`, default 50000: `mclk` cycles per display digit slot; must be >= 1.
- `mclk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle pulse; run or resume counting.
- `stop`  in  1  one-cycle pulse; pause counting.
- `clear`  in  1  one-cycle pulse; return to idle and zero the count.
- `bcd`  out  16  count value, digit3..digit0 = [15:12]..[3:0]; each digit is 0-9.
- `state`  out  2  00 IDLE, 01 RUN, 10 PAUSE.
- `wrap`  out  1  one-cycle pulse when the count rolls over from 9999 to 0000.
- `an`  out  4  digit select, active-low; bit k selects digit k.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Reset** (`rst`=0 at an edge) forces these values:
  - state=IDLE, bcd=0, prescaler=0, scan counter=0, sel=0, wrap=0.
  - Resulting outputs: an=4'b1110, seg=7'b1000000.
- **State machine.** Priority is clear > stop > start when pulses arrive together. Unlisted pulses are ignored.
  - IDLE: start -> RUN.
  - RUN: clear -> IDLE; stop -> PAUSE.
  - PAUSE: clear -> IDLE; start -> RUN.
  - Any state + clear: bcd <= 0, prescaler <= 0. Clear in IDLE is harmless.
- **Prescaler** (width ceil(log2(TICK_DIV))):
  - In RUN it increments each cycle. When it equals TICK_DIV-1 it asserts an internal tick and wraps to 0.
  - In PAUSE it holds its value, so resuming continues the partial period.
  - In IDLE it is held at 0.
- **Counting on tick** (tick is computed from the registered state = RUN):
  - digit0 increments.
  - digit k increments only when digits 0..k-1 are all 9.
  - A digit at 9 that increments becomes 0. All digits update on the same edge.
  - At 9999, a tick yields 0000 and sets `wrap`=1 for exactly one cycle.
  - `wrap`=0 on all other cycles.
- **Simultaneous events:**
  - stop on a tick cycle: the tick still counts, then state becomes PAUSE.
  - clear on a tick cycle: clear wins. bcd=0 and no `wrap`.
  - start while in RUN has no effect.
- **Display scan:**
  - The scan counter runs free in every state.
  - When it reaches SCAN_DIV-1 it wraps, and `sel` advances 0 -> 1 -> 2 -> 3 -> 0.
  - an = ~(1 << sel).
  - seg = decode of digit `sel` of `bcd`: 0:40h, 1:79h, 2:24h, 3:30h, 4:19h, 5:12h, 6:02h, 7:78h, 8:00h, 9:10h.
  - an and seg are combinational decodes of registered `sel` and `bcd` only; there are no combinational paths from inputs.

## Timing
- Command latency:
  - A pulse sampled at edge N changes `state` visibly after edge N.
  - Clear zeroes `bcd` after edge N.
- First count after start from IDLE:
  - If start is sampled at edge N, `bcd` becomes 0001 after edge N+TICK_DIV.
  - Subsequent counts follow every TICK_DIV cycles.
- Pause/resume preserves the phase: total RUN cycles between counts is always TICK_DIV.
- `wrap` is asserted in the same cycle that `bcd` shows 0000.
- Each digit is displayed for SCAN_DIV cycles; a full display refresh takes 4*SCAN_DIV cycles.
- A bcd change is reflected on seg within the same cycle for the currently selected digit.

## Test plan
Use TICK_DIV=4 and SCAN_DIV=2 unless noted.
- **Reset:** hold rst=0 for 3 cycles with random start/stop/clear.
  - Required: state=00, bcd=0000h, wrap=0, an=1110b, seg=40h.
  - Then rst=1 and idle 10 cycles: bcd stays 0000h.
- **Run and carry:** start at edge 0.
  - Required: bcd=0001h after edge 4, 0002h after edge 8.
  - Run to 0009h; the next tick gives 0010h.
  - Preload via run to 0999h; the next tick gives 1000h.
- **Wrap:** run to 9999h; the next tick gives bcd=0000h with wrap=1 for exactly one cycle. Counting continues to 0001h.
- **Pause phase:** start at edge 0, stop at edge 2 (state=10), start at edge 7.
  - Required: bcd=0001h after edge 9, not after edge 11.
  - bcd holds during PAUSE.
- **Priority:**
  - start+stop+clear together in RUN -> IDLE with bcd=0.
  - stop coinciding with the tick edge -> bcd increments and state=PAUSE.
  - clear coinciding with a tick at 9999h -> bcd=0000h and wrap stays 0.
- **Scan:** with bcd=4321h, over 8 cycles:
  - an steps through 1110b, 1101b, 1011b, 0111b, two cycles each.
  - seg shows 79h, 24h, 30h, 19h respectively.
